// File: rtl/gray_sel_seq_if.sv
// Select-stream bundle between the Gray select sequencer and its consumer.
// The master side drives sel/sel_valid/idx/wrap/done; the slave side drives control and sel_ready.
interface gray_sel_seq_if #(
    parameter int KW = 2
);
    logic          start;
    logic          stop;
    logic          dir;
    logic          cont;
    logic          load;
    logic [KW-1:0] load_idx;
    logic          sel_ready;
    logic [KW-1:0] sel;
    logic          sel_valid;
    logic [KW-1:0] idx;
    logic          wrap;
    logic          done;

    modport master (
        input  start, stop, dir, cont, load, load_idx, sel_ready,
        output sel, sel_valid, idx, wrap, done
    );

    modport slave (
        output start, stop, dir, cont, load, load_idx, sel_ready,
        input  sel, sel_valid, idx, wrap, done
    );
endinterface

// File: rtl/gray_sel_seq.sv
// Gray-coded select sequencer (key 0 = no selection); all outputs registered, one cycle after start/handshake.
// Backpressure: while sel_ready is low, sel, idx and sel_valid hold indefinitely.
module gray_sel_seq #(
    parameter int NR = 3,
    parameter int KW = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    gray_sel_seq_if.master     bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [KW-1:0] LAST = KW'(NR - 1);

    function automatic logic [KW-1:0] gray(input logic [KW-1:0] x);
        return x ^ (x >> 1);
    endfunction

    state_t        state_q, state_d;
    logic [KW-1:0] idx_q, idx_d;
    logic [KW-1:0] sel_q, sel_d;
    logic          sel_valid_q, sel_valid_d;
    logic          wrap_q, wrap_d;
    logic          done_q, done_d;

    logic [KW-1:0] load_clamped;
    logic [KW-1:0] next_idx;
    logic          terminal;
    logic          step;

    always_comb begin
        load_clamped = (bus.load_idx > LAST) ? LAST : bus.load_idx;
        terminal     = bus.dir ? (idx_q == '0) : (idx_q == LAST);
        if (bus.dir) begin
            next_idx = (idx_q == '0) ? LAST : idx_q - KW'(1);
        end else begin
            next_idx = (idx_q == LAST) ? '0 : idx_q + KW'(1);
        end
        step = (state_q == RUN) && sel_valid_q && bus.sel_ready && !bus.stop && !bus.load;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;

        // load pre-empts both start and stepping; stop still forces IDLE
        if (bus.load) begin
            idx_d = load_clamped;
        end

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop && !bus.load) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (step) begin
                    idx_d = next_idx;
                    if (terminal) begin
                        if (bus.cont) begin
                            wrap_d = 1'b1;
                        end else begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // idx+1 never exceeds 2^KW-1, so the key is nonzero whenever valid
        sel_valid_d = (state_d == RUN);
        sel_d       = sel_valid_d ? gray(idx_d + KW'(1)) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            wrap_q      <= wrap_d;
            done_q      <= done_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.idx       = idx_q;
    assign bus.wrap      = wrap_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_gray_sel_seq.sv
// Directed bench for gray_sel_seq with NR=3, KW=2: gray(1..3) = 01, 11, 10.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_gray_sel_seq;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    gray_sel_seq_if #(.KW(2)) bus ();

    gray_sel_seq #(.NR(3), .KW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.start = 0; bus.stop = 0; bus.dir = 0; bus.cont = 0;
        bus.load = 0; bus.load_idx = 2'd0; bus.sel_ready = 1;
        tick(); tick();
        n_cmp++; if (bus.sel !== 2'b00) begin n_err++; $display("FAIL reset_sel: got %b want 00", bus.sel); end
        n_cmp++; if (bus.sel_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.sel_valid); end
        n_cmp++; if (bus.idx !== 2'd0) begin n_err++; $display("FAIL reset_idx: got %0d want 0", bus.idx); end
        n_cmp++; if ({bus.wrap, bus.done} !== 2'b00) begin n_err++; $display("FAIL reset_wrap_done: got %b want 00", {bus.wrap, bus.done}); end
        #2 rst_n = 1'b1;
        tick();
        n_cmp++; if (bus.sel_valid !== 1'b0) begin n_err++; $display("FAIL reset_idle_after_release: got %b want 0", bus.sel_valid); end
    endtask

    task automatic test_single_up;
        logic [1:0] exp_sel [3];
        exp_sel[0] = 2'b01; exp_sel[1] = 2'b11; exp_sel[2] = 2'b10;
        bus.dir = 0; bus.cont = 0; bus.sel_ready = 1; bus.start = 1;
        tick();
        bus.start = 0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.sel !== exp_sel[i]) begin n_err++; $display("FAIL up_sel[%0d]: got %b want %b", i, bus.sel, exp_sel[i]); end
            n_cmp++; if (bus.sel_valid !== 1'b1 || bus.done !== 1'b0) begin n_err++; $display("FAIL up_valid_done[%0d]: got %b%b want 10", i, bus.sel_valid, bus.done); end
            tick();
        end
        n_cmp++; if (bus.sel !== 2'b00 || bus.sel_valid !== 1'b0) begin n_err++; $display("FAIL up_end_idle: got sel %b valid %b want 00 0", bus.sel, bus.sel_valid); end
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL up_done_pulse: got %b want 1", bus.done); end
        n_cmp++; if (bus.idx !== 2'd0) begin n_err++; $display("FAIL up_end_idx: got %0d want 0", bus.idx); end
        tick();
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL up_done_single: got %b want 0", bus.done); end
    endtask

    task automatic test_cont_wrap;
        logic [1:0] exp_sel [7];
        logic       exp_wrap;
        exp_sel[0] = 2'b01; exp_sel[1] = 2'b11; exp_sel[2] = 2'b10; exp_sel[3] = 2'b01;
        exp_sel[4] = 2'b11; exp_sel[5] = 2'b10; exp_sel[6] = 2'b01;
        bus.dir = 0; bus.cont = 1; bus.sel_ready = 1; bus.start = 1;
        tick();
        bus.start = 0;
        for (int i = 0; i < 7; i++) begin
            exp_wrap = (i == 3) || (i == 6);
            n_cmp++; if (bus.sel !== exp_sel[i]) begin n_err++; $display("FAIL cont_sel[%0d]: got %b want %b", i, bus.sel, exp_sel[i]); end
            n_cmp++; if (bus.wrap !== exp_wrap) begin n_err++; $display("FAIL cont_wrap[%0d]: got %b want %b", i, bus.wrap, exp_wrap); end
            if (i < 6) tick();
        end
        bus.stop = 1; bus.cont = 0;
        tick();
        bus.stop = 0;
        n_cmp++; if (bus.sel_valid !== 1'b0 || bus.sel !== 2'b00) begin n_err++; $display("FAIL cont_stop: got valid %b sel %b want 0 00", bus.sel_valid, bus.sel); end
        n_cmp++; if (bus.idx !== 2'd0) begin n_err++; $display("FAIL cont_stop_idx_hold: got %0d want 0", bus.idx); end
    endtask

    task automatic test_down_pass;
        logic [1:0] exp_sel [3];
        exp_sel[0] = 2'b10; exp_sel[1] = 2'b11; exp_sel[2] = 2'b01;
        bus.dir = 1; bus.cont = 0; bus.load = 1; bus.load_idx = 2'd2;
        tick();
        bus.load = 0;
        n_cmp++; if (bus.idx !== 2'd2 || bus.sel_valid !== 1'b0) begin n_err++; $display("FAIL down_load_idle: got idx %0d valid %b want 2 0", bus.idx, bus.sel_valid); end
        bus.start = 1;
        tick();
        bus.start = 0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.sel !== exp_sel[i]) begin n_err++; $display("FAIL down_sel[%0d]: got %b want %b", i, bus.sel, exp_sel[i]); end
            tick();
        end
        n_cmp++; if (bus.sel_valid !== 1'b0 || bus.done !== 1'b1) begin n_err++; $display("FAIL down_done: got valid %b done %b want 0 1", bus.sel_valid, bus.done); end
        n_cmp++; if (bus.idx !== 2'd2) begin n_err++; $display("FAIL down_end_idx: got %0d want 2", bus.idx); end
    endtask

    task automatic test_backpressure;
        bus.dir = 0; bus.cont = 1; bus.load = 1; bus.load_idx = 2'd1;
        tick();
        bus.load = 0; bus.sel_ready = 0; bus.start = 1;
        tick();
        bus.start = 0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.sel !== 2'b11 || bus.sel_valid !== 1'b1 || bus.idx !== 2'd1) begin
                n_err++; $display("FAIL bp_hold[%0d]: got sel %b valid %b idx %0d want 11 1 1", i, bus.sel, bus.sel_valid, bus.idx);
            end
            tick();
        end
        bus.sel_ready = 1;
        tick();
        n_cmp++; if (bus.sel !== 2'b10 || bus.idx !== 2'd2) begin n_err++; $display("FAIL bp_release: got sel %b idx %0d want 10 2", bus.sel, bus.idx); end
    endtask

    task automatic test_load_in_run;
        bus.load = 1; bus.load_idx = 2'd0;
        tick();
        n_cmp++; if (bus.idx !== 2'd0 || bus.sel !== 2'b01 || bus.sel_valid !== 1'b1) begin
            n_err++; $display("FAIL run_load0: got idx %0d sel %b valid %b want 0 01 1", bus.idx, bus.sel, bus.sel_valid);
        end
        bus.load_idx = 2'd3;
        tick();
        n_cmp++; if (bus.idx !== 2'd2 || bus.sel !== 2'b10) begin n_err++; $display("FAIL run_load_clamp: got idx %0d sel %b want 2 10", bus.idx, bus.sel); end
        tick();
        n_cmp++; if (bus.idx !== 2'd2 || bus.wrap !== 1'b0) begin n_err++; $display("FAIL run_load_no_step: got idx %0d wrap %b want 2 0", bus.idx, bus.wrap); end
        bus.load = 0; bus.stop = 1;
        tick();
        bus.start = 1;
        tick();
        bus.start = 0; bus.stop = 0;
        n_cmp++; if (bus.sel_valid !== 1'b0 || bus.sel !== 2'b00) begin n_err++; $display("FAIL start_stop_idle: got valid %b sel %b want 0 00", bus.sel_valid, bus.sel); end
    endtask

    task automatic test_async_reset;
        bus.dir = 0; bus.cont = 1; bus.sel_ready = 1; bus.start = 1;
        tick();
        bus.start = 0;
        tick();
        n_cmp++; if (bus.wrap !== 1'b1 || bus.sel !== 2'b01) begin n_err++; $display("FAIL pre_reset_wrap: got wrap %b sel %b want 1 01", bus.wrap, bus.sel); end
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.sel, bus.sel_valid, bus.idx, bus.wrap, bus.done} !== 7'b0) begin
            n_err++; $display("FAIL async_reset: got sel %b valid %b idx %0d wrap %b done %b want all 0", bus.sel, bus.sel_valid, bus.idx, bus.wrap, bus.done);
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bus.sel_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_idle[%0d]: got %b want 0", i, bus.sel_valid); end
        end
        bus.start = 1;
        tick();
        bus.start = 0;
        n_cmp++; if (bus.sel_valid !== 1'b1 || bus.sel !== 2'b01) begin n_err++; $display("FAIL restart: got valid %b sel %b want 1 01", bus.sel_valid, bus.sel); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_up();
        test_cont_wrap();
        test_down_pass();
        test_backpressure();
        test_load_in_run();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
